// File: rtl/ofdm_tx_sched_pkg.sv
// Shared types and default widths for the OFDM TX command scheduler.
// Optional per-requester statistics are enabled with OFDM_TX_SCHED_STATS_EN.
package ofdm_tx_sched_pkg;

  localparam int NREQ_DEF    = 2;
  localparam int LEN_W_DEF   = 8;
  localparam int PAUSE_W_DEF = 22;
  localparam int CNT_W_DEF   = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_STREAM    = 3'd3,
    ST_PAUSE     = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [LEN_W_DEF-1:0]   length;
    logic [1:0]             mode;
    logic [PAUSE_W_DEF-1:0] pause;
  } tx_cmd_t;

  // Fold a position in [0, 2n) back into [0, n).
  function automatic int rr_wrap(input int idx, input int n);
    if (idx >= n) begin
      return idx - n;
    end else begin
      return idx;
    end
  endfunction

endpackage

// File: rtl/ofdm_tx_rr_arb.sv
// Round-robin arbiter: the requester at or after ptr (wrapping) wins, one-hot grant.
module ofdm_tx_rr_arb
  import ofdm_tx_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  int   pos_s;
  logic found_s;

  // scan requesters in priority order starting at ptr
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    pos_s   = 32'sd0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = rr_wrap(int'(ptr) + k, NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!found_s && (i == pos_s) && req[i]) begin
          grant[i] = 1'b1;
          found_s  = 1'b1;
        end else begin
          grant[i] = grant[i];
        end
      end
    end
  end

endmodule

// File: rtl/ofdm_tx_cmd_sched.sv
// Arbitrates requester commands, waits for FIFO data, issues, streams and pauses.
// Define OFDM_TX_SCHED_STATS_EN to add per-requester accepted-command counters (frame_cnt).
module ofdm_tx_cmd_sched
  import ofdm_tx_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int PAUSE_W = PAUSE_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      up_clk,
  input  logic                      up_rstn,
  input  logic                      enable,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*LEN_W-1:0]     req_length,
  input  logic [NREQ*2-1:0]         req_mode,
  input  logic [NREQ*PAUSE_W-1:0]   req_pause,
  input  logic [CNT_W-1:0]          dataq_rdcnt,
  input  logic                      din_fire,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [LEN_W-1:0]          cmd_length,
  output logic [1:0]                cmd_mode,
  output logic [PAUSE_W-1:0]        cmd_pause,
  output logic [$clog2(NREQ)-1:0]   cmd_owner,
`ifdef OFDM_TX_SCHED_STATS_EN
  output logic [NREQ*16-1:0]        frame_cnt,
`endif
  output logic                      busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = (CNT_W > LEN_W) ? CNT_W : LEN_W;
  localparam logic [OW-1:0] LAST_IDX = OW'(NREQ - 1);

  sched_state_e       state_r, state_nxt_s;
  logic [OW-1:0]      ptr_r, grant_idx_s;
  logic [NREQ-1:0]    grant_s, req_ready_s;
  logic               grant_en_s, last_word_s;
  logic [LEN_W-1:0]   sel_len_s, cmd_length_r, word_cnt_r;
  logic [1:0]         sel_mode_s, cmd_mode_r;
  logic [PAUSE_W-1:0] sel_pause_s, cmd_pause_r, pause_cnt_r;
  logic [OW-1:0]      cmd_owner_r;
  logic               cmd_valid_r, busy_r;
  logic [CW-1:0]      rdcnt_ext_s, len_ext_s;

  // Grants are only possible from IDLE and never while reset is asserted.
  assign grant_en_s  = up_rstn && enable && (state_r == ST_IDLE);
  assign rdcnt_ext_s = CW'(dataq_rdcnt);
  assign len_ext_s   = CW'(cmd_length_r);
  assign last_word_s = ((word_cnt_r + LEN_W'(1'b1)) == cmd_length_r);

  ofdm_tx_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // gate the grant and pick the winning requester's index and fields
  always_comb begin
    req_ready_s = grant_s & {NREQ{grant_en_s}};
    grant_idx_s = '0;
    sel_len_s   = '0;
    sel_mode_s  = '0;
    sel_pause_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        grant_idx_s = OW'(i);
        sel_len_s   = req_length[i*LEN_W +: LEN_W];
        sel_mode_s  = req_mode[i*2 +: 2];
        sel_pause_s = req_pause[i*PAUSE_W +: PAUSE_W];
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_ready_s) state_nxt_s = ST_WAIT_DATA;
        else              state_nxt_s = ST_IDLE;
      end
      ST_WAIT_DATA: begin
        if (rdcnt_ext_s >= len_ext_s) state_nxt_s = ST_ISSUE;
        else                          state_nxt_s = ST_WAIT_DATA;
      end
      ST_ISSUE: begin
        if (!cmd_ready)                         state_nxt_s = ST_ISSUE;
        else if (cmd_length_r != '0)            state_nxt_s = ST_STREAM;
        else if (cmd_pause_r != '0)             state_nxt_s = ST_PAUSE;
        else                                    state_nxt_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (!(din_fire && last_word_s))         state_nxt_s = ST_STREAM;
        else if (cmd_pause_r != '0)             state_nxt_s = ST_PAUSE;
        else                                    state_nxt_s = ST_IDLE;
      end
      ST_PAUSE: begin
        if (pause_cnt_r <= PAUSE_W'(1'b1)) state_nxt_s = ST_IDLE;
        else                               state_nxt_s = ST_PAUSE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state, command latch, round-robin pointer, counters and registered status
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      cmd_length_r <= '0;
      cmd_mode_r   <= '0;
      cmd_pause_r  <= '0;
      cmd_owner_r  <= '0;
      word_cnt_r   <= '0;
      pause_cnt_r  <= '0;
      cmd_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cmd_valid_r <= (state_nxt_s == ST_ISSUE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (|req_ready_s) begin
        cmd_length_r <= sel_len_s;
        cmd_mode_r   <= sel_mode_s;
        cmd_pause_r  <= sel_pause_s;
        cmd_owner_r  <= grant_idx_s;
        ptr_r        <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + OW'(1'b1);
      end else begin
        ptr_r <= ptr_r;
      end
      if (state_r == ST_ISSUE) begin
        word_cnt_r <= '0;
      end else if ((state_r == ST_STREAM) && din_fire) begin
        word_cnt_r <= word_cnt_r + LEN_W'(1'b1);
      end else begin
        word_cnt_r <= word_cnt_r;
      end
      // the pause counter loads on entry and counts down to the final PAUSE cycle
      if ((state_nxt_s == ST_PAUSE) && (state_r != ST_PAUSE)) begin
        pause_cnt_r <= cmd_pause_r;
      end else if (state_r == ST_PAUSE) begin
        pause_cnt_r <= pause_cnt_r - PAUSE_W'(1'b1);
      end else begin
        pause_cnt_r <= pause_cnt_r;
      end
    end
  end

  assign req_ready  = req_ready_s;
  assign cmd_valid  = cmd_valid_r;
  assign busy       = busy_r;
  assign cmd_length = cmd_length_r;
  assign cmd_mode   = cmd_mode_r;
  assign cmd_pause  = cmd_pause_r;
  assign cmd_owner  = cmd_owner_r;

`ifdef OFDM_TX_SCHED_STATS_EN
  logic [15:0] frame_cnt_r [NREQ];

  // saturating per-requester count of commands accepted by the TX core
  always_ff @(posedge up_clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!up_rstn) begin
        frame_cnt_r[i] <= 16'd0;
      end else if ((state_r == ST_ISSUE) && cmd_ready && (cmd_owner_r == OW'(i)) &&
                   (frame_cnt_r[i] != 16'hFFFF)) begin
        frame_cnt_r[i] <= frame_cnt_r[i] + 16'd1;
      end else begin
        frame_cnt_r[i] <= frame_cnt_r[i];
      end
    end
  end

  // flatten the counters onto the output bus
  always_comb begin
    frame_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      frame_cnt[i*16 +: 16] = frame_cnt_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_tx_cmd_sched.sv
// Self-checking bench: directed scenarios plus randomized frames checked against a
// frame-level timeline model (grant order, data wait, issue stall, stream, pause).
module tb_ofdm_tx_cmd_sched;

  localparam int NREQ = 3, LEN_W = 8, PAUSE_W = 22, CNT_W = 10, OW = $clog2(NREQ);

  logic                    up_clk = 1'b0;
  logic                    up_rstn, enable, din_fire, cmd_ready;
  logic [NREQ-1:0]         req_valid, req_ready;
  logic [NREQ*LEN_W-1:0]   req_length;
  logic [NREQ*2-1:0]       req_mode;
  logic [NREQ*PAUSE_W-1:0] req_pause;
  logic [CNT_W-1:0]        dataq_rdcnt;
  logic                    cmd_valid, busy;
  logic [LEN_W-1:0]        cmd_length;
  logic [1:0]              cmd_mode;
  logic [PAUSE_W-1:0]      cmd_pause;
  logic [OW-1:0]           cmd_owner;
`ifdef OFDM_TX_SCHED_STATS_EN
  logic [NREQ*16-1:0]      frame_cnt;
`endif

  logic [LEN_W-1:0]   len_a   [NREQ];
  logic [1:0]         mode_a  [NREQ];
  logic [PAUSE_W-1:0] pause_a [NREQ];
  int                 stat_a  [NREQ];
  int                 n_checks = 0, n_errors = 0;
  int                 last_grant;
  bit                 scramble;
  logic [NREQ-1:0]    g;

  always #5 up_clk = ~up_clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_length[i*LEN_W +: LEN_W]     = len_a[i];
      req_mode[i*2 +: 2]               = mode_a[i];
      req_pause[i*PAUSE_W +: PAUSE_W]  = pause_a[i];
    end
  end

  ofdm_tx_cmd_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .PAUSE_W(PAUSE_W), .CNT_W(CNT_W)) dut (
    .up_clk(up_clk), .up_rstn(up_rstn), .enable(enable), .req_valid(req_valid),
    .req_ready(req_ready), .req_length(req_length), .req_mode(req_mode), .req_pause(req_pause),
    .dataq_rdcnt(dataq_rdcnt), .din_fire(din_fire), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_length(cmd_length), .cmd_mode(cmd_mode), .cmd_pause(cmd_pause), .cmd_owner(cmd_owner),
`ifdef OFDM_TX_SCHED_STATS_EN
    .frame_cnt(frame_cnt),
`endif
    .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  // Winner = first valid requester after the last one granted, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] v);
    int w = -1;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (w < 0 && i == (last_grant + 1 + k) % NREQ && v[i]) w = i;
      end
    end
    return w;
  endfunction

  task automatic scramble_reqs();
    if (scramble) begin
      req_valid = NREQ'($urandom);
      enable    = 1'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        len_a[i]   = LEN_W'($urandom);
        mode_a[i]  = 2'($urandom);
        pause_a[i] = PAUSE_W'($urandom);
      end
    end
  endtask

  task automatic check_cmd(input string tag, input int w, input logic [LEN_W-1:0] l,
                           input logic [1:0] m, input logic [PAUSE_W-1:0] p);
    check_val({tag, "_valid"}, 32'(cmd_valid), 32'd1);
    check_val({tag, "_len"},   32'(cmd_length), 32'(l));
    check_val({tag, "_mode"},  32'(cmd_mode), 32'(m));
    check_val({tag, "_pause"}, 32'(cmd_pause), 32'(p));
    check_val({tag, "_owner"}, 32'(cmd_owner), 32'(w));
    check_val({tag, "_rdy0"},  32'(req_ready), 32'd0);
  endtask

  // One whole frame starting in an IDLE cycle with req_valid/fields already driven.
  task automatic run_frame(input int nwait, input int nstall, input int fire_pct,
                           input int wait_rd, input int pass_rd, output logic [NREQ-1:0] got);
    int w, fires, guard;
    logic [LEN_W-1:0]   el;
    logic [1:0]         em;
    logic [PAUSE_W-1:0] ep;
    logic [NREQ-1:0]    onehot;
    w  = rr_pick(req_valid);
    if (w < 0) w = 0;
    el = len_a[w]; em = mode_a[w]; ep = pause_a[w];
    if (el == '0) nwait = 0;
    onehot = '0;
    for (int i = 0; i < NREQ; i++) onehot[i] = (i == w);
    #1;
    got = req_ready;
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("grant", 32'(req_ready), 32'(onehot));
    last_grant = w;
    tick();
    for (int i = 0; i < nwait; i++) begin
      scramble_reqs();
      din_fire    = 1'($urandom);
      dataq_rdcnt = CNT_W'((wait_rd >= 0) ? wait_rd : int'($urandom_range(int'(el) - 1, 0)));
      #1;
      check_val("wait_valid", 32'(cmd_valid), 32'd0);
      check_val("wait_busy", 32'(busy), 32'd1);
      check_val("wait_rdy0", 32'(req_ready), 32'd0);
      tick();
    end
    scramble_reqs();
    dataq_rdcnt = CNT_W'((pass_rd >= 0) ? pass_rd : int'($urandom_range(1023, int'(el))));
    #1;
    check_val("pass_valid", 32'(cmd_valid), 32'd0);
    check_val("pass_busy", 32'(busy), 32'd1);
    tick();
    for (int i = 0; i <= nstall; i++) begin
      scramble_reqs();
      din_fire  = 1'($urandom);
      cmd_ready = (i == nstall);
      #1;
      check_cmd("issue", w, el, em, ep);
      tick();
    end
    cmd_ready = 1'b0;
    stat_a[w] = stat_a[w] + 1;
    fires = 0; guard = 0;
    while (fires < int'(el)) begin
      scramble_reqs();
      din_fire = (guard > 50) || (int'($urandom_range(99, 0)) < fire_pct);
      #1;
      check_val("stream_busy", 32'(busy), 32'd1);
      check_val("stream_valid", 32'(cmd_valid), 32'd0);
      if (din_fire) fires++;
      guard++;
      tick();
    end
    for (int i = 0; i < int'(ep); i++) begin
      scramble_reqs();
      din_fire = 1'($urandom);
      #1;
      check_val("pause_busy", 32'(busy), 32'd1);
      check_val("pause_valid", 32'(cmd_valid), 32'd0);
      tick();
    end
    din_fire = 1'b0;
  endtask

  task automatic set_req(input int i, input int l, input int p, input int m);
    len_a[i] = LEN_W'(l); pause_a[i] = PAUSE_W'(p); mode_a[i] = 2'(m);
  endtask

  initial begin
    up_rstn = 1'b0; enable = 1'b0; req_valid = '0; din_fire = 1'b0; cmd_ready = 1'b0;
    dataq_rdcnt = '0; scramble = 1'b0;
    for (int i = 0; i < NREQ; i++) begin set_req(i, 0, 0, 0); stat_a[i] = 0; end
    repeat (3) tick();
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_valid", 32'(cmd_valid), 32'd0);
    check_val("rst_len", 32'(cmd_length), 32'd0);
    check_val("rst_owner", 32'(cmd_owner), 32'd0);
    up_rstn = 1'b1; last_grant = NREQ - 1;
    tick();

    // req0 and req1 held continuously: grants alternate starting at 0
    enable = 1'b1; req_valid = 3'b011;
    set_req(0, 1, 0, 1); set_req(1, 1, 0, 2);
    for (int i = 0; i < 4; i++) begin
      run_frame(0, 0, 100, -1, -1, g);
      check_val("alt_grant", 32'(g), (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // len 4, pause 3, plentiful data, immediate accept
    req_valid = 3'b001; set_req(0, 4, 3, 2);
    run_frame(0, 0, 100, -1, 10, g);
    req_valid = '0;
    #1; check_val("a_done_idle", 32'(busy), 32'd0);
    tick();

    // len 8 waits on rdcnt 5, issues after rdcnt 8
    req_valid = 3'b001; set_req(0, 8, 0, 3);
    run_frame(3, 0, 70, 5, 8, g);

    // len 0, pause 0: single issue cycle then idle
    req_valid = 3'b100; set_req(2, 0, 0, 1);
    run_frame(0, 0, 100, -1, -1, g);
    req_valid = '0;
    #1; check_val("d_idle", 32'(busy), 32'd0);
    tick();
    #1; check_val("d_stay_idle", 32'(busy), 32'd0);
    tick();

    // cmd_ready held low for 5 cycles
    req_valid = 3'b010; set_req(1, 2, 1, 0);
    run_frame(0, 5, 100, -1, -1, g);

    // enable low blocks new grants
    enable = 1'b0; req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("en0_rdy", 32'(req_ready), 32'd0);
      check_val("en0_busy", 32'(busy), 32'd0);
      tick();
    end

    // reset in the middle of STREAM
    enable = 1'b1; req_valid = 3'b010; set_req(1, 4, 2, 3); dataq_rdcnt = CNT_W'(1023);
    #1; check_val("mid_grant", 32'(req_ready), 32'd2);
    last_grant = 1;
    tick(); tick();
    cmd_ready = 1'b1; tick();
    cmd_ready = 1'b0; din_fire = 1'b1;
    #1; check_val("mid_stream_busy", 32'(busy), 32'd1);
    tick();
    din_fire = 1'b0; up_rstn = 1'b0;
    tick();
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_valid", 32'(cmd_valid), 32'd0);
    check_val("mid_rst_rdy", 32'(req_ready), 32'd0);
    check_val("mid_rst_len", 32'(cmd_length), 32'd0);
    check_val("mid_rst_mode", 32'(cmd_mode), 32'd0);
    check_val("mid_rst_pause", 32'(cmd_pause), 32'd0);
    check_val("mid_rst_owner", 32'(cmd_owner), 32'd0);
    up_rstn = 1'b1; last_grant = NREQ - 1;
    for (int i = 0; i < NREQ; i++) stat_a[i] = 0;
    req_valid = 3'b111; set_req(0, 1, 1, 0);
    run_frame(0, 0, 100, -1, -1, g);
    check_val("post_rst_first", 32'(g), 32'd1);

    // randomized frames with idle gaps and garbage on inputs while busy
    for (int f = 0; f < 150; f++) begin
      scramble = 1'b0;
      for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
        enable = 1'b0; req_valid = NREQ'($urandom);
        #1;
        check_val("gap_rdy", 32'(req_ready), 32'd0);
        check_val("gap_busy", 32'(busy), 32'd0);
        tick();
      end
      enable = 1'b1;
      req_valid = NREQ'($urandom_range((1 << NREQ) - 1, 1));
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(6, 1)),
                int'($urandom_range(4, 0)), int'($urandom_range(3, 0)));
      end
      scramble = 1'b1;
      run_frame(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 60, -1, -1, g);
    end
    scramble = 1'b0; req_valid = '0; enable = 1'b1;
    #1; check_val("end_idle", 32'(busy), 32'd0);
`ifdef OFDM_TX_SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++) check_val("frame_cnt", 32'(frame_cnt[i*16 +: 16]), 32'(stat_a[i]));
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ofdm_tx_cmd_sched.md
OFDM_TX_CMD_SCHED -- requirements
Module: ofdm_tx_cmd_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, giving the number of command requesters (2..4).
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the command length width in data words.
REQ-003 The block SHALL have parameter PAUSE_W, default 22, giving the post-frame pause width in sample clocks.
REQ-004 The block SHALL have parameter CNT_W, default 10, giving the data-FIFO read-count width.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset.
REQ-006 Port up_clk, input, 1: the single clock (TX sample clock).
REQ-007 Port up_rstn, input, 1: synchronous active-low reset.
REQ-008 Port enable, input, 1: allows new grants when high.
REQ-009 Port req_valid, input, NREQ: per-requester command-valid flags.
REQ-010 Port req_ready, output, NREQ: one-hot, one-cycle accept pulse.
REQ-011 Port req_length, input, NREQ*LEN_W: packed per-requester command lengths.
REQ-012 Port req_mode, input, NREQ*2: packed per-requester command modes.
REQ-013 Port req_pause, input, NREQ*PAUSE_W: packed per-requester pause lengths.
REQ-014 Port dataq_rdcnt, input, CNT_W: data-FIFO words available.
REQ-015 Port din_fire, input, 1: one data word consumed by the TX core this cycle.
REQ-016 Port cmd_valid, output, 1: command offered to the TX core.
REQ-017 Port cmd_ready, input, 1: TX core accepts the command.
REQ-018 Ports cmd_length (LEN_W), cmd_mode (2) and cmd_pause (PAUSE_W), outputs: latched command fields.
REQ-019 Port cmd_owner, output, $clog2(NREQ): index of the granted requester.
REQ-020 Port busy, output, 1: high in every state except IDLE.

Function
REQ-021 The FSM SHALL use the states IDLE, WAIT_DATA, ISSUE, STREAM and PAUSE.
REQ-022 In IDLE, with enable=1 and any req_valid set, the block SHALL pick one requester by round-robin starting after the last grant, pulse its req_ready for one cycle, latch its fields and owner, and enter WAIT_DATA the next cycle.
REQ-023 After reset, round-robin priority SHALL start at requester 0, and a requester granted last SHALL have lowest priority at the next arbitration.
REQ-024 WAIT_DATA SHALL move to ISSUE when dataq_rdcnt >= cmd_length (zero-extended compare) and stay otherwise; length 0 SHALL pass at once.
REQ-025 In ISSUE, cmd_valid SHALL be 1 and the cmd_* fields SHALL stay stable until cmd_ready=1, with no combinational path from cmd_ready to cmd_valid.
REQ-026 When the command is accepted in ISSUE, the block SHALL enter STREAM and clear the word counter, or skip to PAUSE when length=0, or skip to IDLE when length=0 and pause=0.
REQ-027 In STREAM, the block SHALL count din_fire and leave in the cycle the count reaches cmd_length, entering PAUSE if pause≠0 and IDLE otherwise.
REQ-028 In STREAM, din_fire SHALL be ignored in every other state.
REQ-029 PAUSE SHALL last exactly cmd_pause cycles, then the block SHALL return to IDLE.
REQ-030 enable=0 SHALL block only new grants, and an in-flight command SHALL complete.
REQ-031 A request SHALL be granted in the IDLE cycle it is seen, and two back-to-back frames SHALL have exactly one IDLE cycle between them.

Reset
REQ-032 On up_rstn=0 at a clock edge, state SHALL become IDLE, req_ready=0, cmd_valid=0, busy=0, cmd_* fields=0, cmd_owner=0, counters=0, and the round-robin pointer SHALL point at requester 0.
REQ-033 A reset during any state SHALL abandon the command with no further outputs.

Configuration
REQ-034 When OFDM_TX_SCHED_STATS_EN is defined, the block SHALL add output frame_cnt of NREQ*16 bits, with one 16-bit saturating counter per requester incremented on each accepted command and cleared by reset.
REQ-035 When OFDM_TX_SCHED_STATS_EN is undefined, frame_cnt and its logic SHALL be absent.

Structure
REQ-036 Package ofdm_tx_sched_pkg SHALL hold the FSM state enum, the command record type (length, mode, pause) and the default width constants.
REQ-037 The round-robin arbiter SHALL be the sub-module ofdm_tx_rr_arb, taking request and pointer in and giving a one-hot grant out.

Verification
REQ-038 With req0 (len=4, pause=3), rdcnt=10 and cmd_ready=1, the bench SHALL see req_ready[0] pulse, cmd_valid for one cycle, 4 din_fire then 3 PAUSE cycles, then busy=0.
REQ-039 With req0 and req1 held valid continuously, the bench SHALL see grants alternating 0,1,0,1.
REQ-040 With len=8 and rdcnt=5, the bench SHALL see the block stay in WAIT_DATA with cmd_valid=0, and ISSUE one cycle after rdcnt=8.
REQ-041 With len=0 and pause=0, the bench SHALL see a single cmd_valid, no STREAM or PAUSE, and a return to IDLE.
REQ-042 With cmd_ready held low for 5 cycles, the bench SHALL see cmd_valid and the fields stable for 5 cycles, then STREAM.
REQ-043 With up_rstn=0 mid-STREAM, the bench SHALL see all outputs at reset values on the next edge and requester 0 granted first afterwards.
